// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bundle between the branch control/hazard logic, instruction
// memory and the PC redirect unit.
interface pc_redirect_unit_if;
  logic [1:0]  branch_sel;
  logic        resolve_valid;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic        fetch_req;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_exc;

  // master: the PC redirect unit (owns pc and the fetch request)
  modport master (
    input  branch_sel, resolve_valid, branch_target, jump_target, stall, imem_ready,
    output pc, fetch_req, flush_if_id, flush_id_ex, misalign_exc
  );

  // slave: pipeline control and instruction memory side
  modport slave (
    output branch_sel, resolve_valid, branch_target, jump_target, stall, imem_ready,
    input  pc, fetch_req, flush_if_id, flush_id_ex, misalign_exc
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// PC generation with branch/jump redirect, pipeline flush and fetch request.
// Optional macro PC_MISALIGN_CHECK_EN traps misaligned redirect targets into HALT.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_redirect_unit_if.master    bus
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        taken;
  logic        run_taken;
  logic        fetch_req;
  logic [31:0] target_raw;
  logic [31:0] target_aligned;

  assign taken          = bus.resolve_valid && (bus.branch_sel != 2'b00);
  assign run_taken      = taken && (state_reg == RUN);
  assign target_raw     = bus.branch_sel[1] ? bus.jump_target : bus.branch_target;
  assign target_aligned = target_raw & ~32'h0000_0003;
  assign fetch_req      = (state_reg == RUN) && !bus.stall;

`ifdef PC_MISALIGN_CHECK_EN
  logic misaligned;
  logic misalign_exc_reg;

  assign misaligned = (target_raw[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= BOOT;
      pc_reg           <= RESET_VECTOR;
      misalign_exc_reg <= 1'b0;
    end else begin
      misalign_exc_reg <= 1'b0;
      case (state_reg)
        BOOT:     state_reg <= RUN;
        RUN: begin
          // A redirect wins over stall and abandons any unaccepted request.
          if (run_taken) begin
            if (misaligned) begin
              misalign_exc_reg <= 1'b1;
              state_reg        <= HALT;
            end else begin
              pc_reg    <= target_aligned;
              state_reg <= REDIRECT;
            end
          end else if (fetch_req && bus.imem_ready) begin
            pc_reg <= pc_reg + 32'(PC_STEP);
          end
        end
        REDIRECT: state_reg <= RUN;
        HALT:     state_reg <= HALT;
        default:  state_reg <= BOOT;
      endcase
    end
  end

  assign bus.misalign_exc = misalign_exc_reg;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
    end else begin
      case (state_reg)
        BOOT:     state_reg <= RUN;
        RUN: begin
          // A redirect wins over stall and abandons any unaccepted request.
          if (run_taken) begin
            pc_reg    <= target_aligned;
            state_reg <= REDIRECT;
          end else if (fetch_req && bus.imem_ready) begin
            pc_reg <= pc_reg + 32'(PC_STEP);
          end
        end
        REDIRECT: state_reg <= RUN;
        default:  state_reg <= BOOT;
      endcase
    end
  end

  assign bus.misalign_exc = 1'b0;
`endif

  assign bus.pc          = pc_reg;
  assign bus.fetch_req   = fetch_req;
  assign bus.flush_if_id = run_taken;
  assign bus.flush_id_ex = run_taken;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed table-driven bench for pc_redirect_unit, plus hand-written
// sequences for misaligned targets and reset in the middle of a redirect.
module tb_pc_redirect_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  pc_redirect_unit_if bus ();

  pc_redirect_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .PC_STEP      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        stall;
    logic        rdy;
    logic [31:0] exp_pc;
    logic        exp_fetch;
    logic        exp_flush;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [1:0] sel, input logic [31:0] bt,
                       input logic [31:0] jt, input logic stall, input logic rdy);
    bus.resolve_valid = rv;
    bus.branch_sel    = sel;
    bus.branch_target = bt;
    bus.jump_target   = jt;
    bus.stall         = stall;
    bus.imem_ready    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //               rv    sel    branch_tgt     jump_tgt       stall rdy   exp_pc         fetch flush
    vecs[0]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0}; // BOOT
    vecs[1]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 32'h0,         32'h0000_0100, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1}; // jump to 0x100
    vecs[5]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0}; // REDIRECT
    vecs[6]  = '{1'b1, 2'b01, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1}; // branch to 0x40
    vecs[7]  = '{1'b1, 2'b01, 32'h0000_0080, 32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0}; // ignored in REDIRECT
    vecs[8]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0044, 1'b1, 1'b0}; // not ready: hold
    vecs[10] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0044, 1'b0, 1'b0}; // stall: hold
    vecs[11] = '{1'b1, 2'b11, 32'h0,         32'h0000_2000, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b1}; // jump under stall
    vecs[12] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b11, 32'h0,         32'h0000_3000, 1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b0}; // rv=0 gates
    vecs[14] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_2004, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 2'b10, 32'h0,         32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0000_2008, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0}; // wrapped

    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check("reset_pc", bus.pc, 32'h0);
    check("reset_fetch", 32'(bus.fetch_req), 32'h0);
    check("reset_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h0);
    check("reset_misalign", 32'(bus.misalign_exc), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rv, vecs[i].sel, vecs[i].bt, vecs[i].jt, vecs[i].stall, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_pc", i), bus.pc, vecs[i].exp_pc);
      check($sformatf("v%0d_fetch", i), 32'(bus.fetch_req), 32'(vecs[i].exp_fetch));
      check($sformatf("v%0d_flush_if_id", i), 32'(bus.flush_if_id), 32'(vecs[i].exp_flush));
      check($sformatf("v%0d_flush_id_ex", i), 32'(bus.flush_id_ex), 32'(vecs[i].exp_flush));
      check($sformatf("v%0d_misalign", i), 32'(bus.misalign_exc), 32'h0);
      $display("[TB] vec %0d pc=0x%08h fetch=%0b flush=%0b/%0b", i, bus.pc, bus.fetch_req,
               bus.flush_if_id, bus.flush_id_ex);
      step();
    end

    // Misaligned branch target from pc=0x4
    drive(1'b1, 2'b01, 32'h0000_0042, 32'h0, 1'b0, 1'b1);
    #1;
    check("mis_pc_before", bus.pc, 32'h0000_0004);
    check("mis_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h3);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_pc_hold", bus.pc, 32'h0000_0004);
    check("mis_exc_pulse", 32'(bus.misalign_exc), 32'h1);
    check("mis_halt_fetch", 32'(bus.fetch_req), 32'h0);
    step();
    check("mis_exc_clear", 32'(bus.misalign_exc), 32'h0);
    check("mis_halt_fetch2", 32'(bus.fetch_req), 32'h0);
    drive(1'b1, 2'b10, 32'h0, 32'h0000_0500, 1'b0, 1'b1);
    #1;
    check("halt_no_flush", 32'({bus.flush_if_id, bus.flush_id_ex}), 32'h0);
    step();
    step();
    check("halt_pc_hold", bus.pc, 32'h0000_0004);
    check("halt_fetch", 32'(bus.fetch_req), 32'h0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
`else
    check("mis_pc_aligned", bus.pc, 32'h0000_0040);
    check("mis_redirect_fetch", 32'(bus.fetch_req), 32'h0);
    check("mis_exc_tied", 32'(bus.misalign_exc), 32'h0);
    step();
    check("mis_fetch_resume", 32'(bus.fetch_req), 32'h1);
    check("mis_pc_resume", bus.pc, 32'h0000_0040);
`endif
    $display("[TB] misaligned sequence pc=0x%08h exc=%0b", bus.pc, bus.misalign_exc);

    // Reset recovery, then reset asserted mid-redirect
    #2 rst_n = 1'b0;
    #1;
    check("rst1_pc", bus.pc, 32'h0);
    check("rst1_fetch", 32'(bus.fetch_req), 32'h0);
    check("rst1_misalign", 32'(bus.misalign_exc), 32'h0);
    step();
    rst_n = 1'b1;
    check("boot1_fetch", 32'(bus.fetch_req), 32'h0);
    step();
    check("run1_fetch", 32'(bus.fetch_req), 32'h1);
    check("run1_pc", bus.pc, 32'h0);
    step();
    check("run1_pc_inc", bus.pc, 32'h0000_0004);
    drive(1'b1, 2'b10, 32'h0, 32'h0000_0300, 1'b0, 1'b1);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check("redir_pc", bus.pc, 32'h0000_0300);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_pc", bus.pc, 32'h0);
    check("rst2_fetch", 32'(bus.fetch_req), 32'h0);
    step();
    rst_n = 1'b1;
    check("boot2_fetch", 32'(bus.fetch_req), 32'h0);
    step();
    check("run2_fetch", 32'(bus.fetch_req), 32'h1);
    check("run2_pc", bus.pc, 32'h0);
    $display("[TB] reset-mid-redirect sequence pc=0x%08h fetch=%0b", bus.pc, bus.fetch_req);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port branch_sel  input  2  redirect select from the branch control unit: 00 sequential, 01 conditional branch taken, 1x jump.
REQ-006 SHALL have port resolve_valid  input  1  branch_sel and targets are valid this cycle.
REQ-007 SHALL have port branch_target  input  32  PC-relative branch target.
REQ-008 SHALL have port jump_target  input  32  jump (JAL/JALR) target.
REQ-009 SHALL have port stall  input  1  hazard stall; freezes sequential fetch.
REQ-010 SHALL have port imem_ready  input  1  instruction memory accepts the current request.
REQ-011 SHALL have port pc  output  32  current fetch address.
REQ-012 SHALL have port fetch_req  output  1  fetch request valid for pc.
REQ-013 SHALL have port flush_if_id  output  1  squash the IF/ID register.
REQ-014 SHALL have port flush_id_ex  output  1  squash the ID/EX register.
REQ-015 SHALL have port misalign_exc  output  1  misaligned-target exception pulse (REQ-033 only).

Function
REQ-016 SHALL implement the FSM states BOOT, RUN, REDIRECT and HALT.
REQ-017 SHALL leave BOOT for RUN after one cycle, with fetch_req low while in BOOT.
REQ-018 SHALL define taken as resolve_valid AND (branch_sel != 2'b00).
REQ-019 SHALL select the target as jump_target when branch_sel[1]=1, else branch_target.
REQ-020 SHALL, in RUN with taken, load pc with the target at the next edge and enter REDIRECT.
REQ-021 SHALL assert flush_if_id and flush_id_ex combinationally in the cycle taken is high in RUN, and keep them low otherwise.
REQ-022 SHALL give taken priority over stall and imem_ready; an outstanding request with imem_ready low is abandoned without waiting.
REQ-023 SHALL hold fetch_req low for exactly one cycle in REDIRECT, then return to RUN.
REQ-024 SHALL ignore taken while in REDIRECT, so back-to-back redirects are not possible.
REQ-025 SHALL drive fetch_req = (state==RUN) AND NOT stall.
REQ-026 SHALL, in RUN without taken, advance pc by PC_STEP only when fetch_req AND imem_ready, and otherwise hold pc.
REQ-027 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC + 4 gives 32'h0000_0000), with no overflow flag.
REQ-028 SHALL treat resolve_valid=0 as no redirect regardless of branch_sel.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force pc=RESET_VECTOR, state=BOOT and misalign_exc=0, with fetch_req, flush_if_id and flush_id_ex low.
REQ-030 SHALL, on reset mid-redirect or mid-fetch, discard the pending target and start at RESET_VECTOR via BOOT.
REQ-031 SHALL take its first rising edge with rst_n=1 in BOOT, and assert fetch_req at RESET_VECTOR on the following cycle.

Configuration
REQ-032 SHALL compile the misaligned-target check in only when macro PC_MISALIGN_CHECK_EN is defined.
REQ-033 SHALL, when PC_MISALIGN_CHECK_EN is defined and taken occurs with target[1:0] != 2'b00: leave pc unchanged, pulse misalign_exc for one cycle, still assert both flushes, and enter HALT.
REQ-034 SHALL keep fetch_req low in HALT and leave HALT only on reset.
REQ-035 SHALL, without PC_MISALIGN_CHECK_EN, clear target[1:0] to 00 before loading pc, tie misalign_exc to 0, and make HALT unreachable.

Verification
REQ-036 SHALL cover reset and sequential fetch: rst_n release, imem_ready=1, stall=0 -> one BOOT cycle, then pc 0x0, 0x4, 0x8 on consecutive cycles.
REQ-037 SHALL cover branch taken: pc=0x100, resolve_valid=1, branch_sel=01, branch_target=0x40 -> both flushes high that cycle, pc=0x40 next, fetch_req low one cycle, then fetch of 0x40.
REQ-038 SHALL cover jump under stall: stall=1, imem_ready=0, branch_sel=11, jump_target=0x2000 -> pc=0x2000 next cycle, and stall does not block the redirect.
REQ-039 SHALL cover wrap-around: pc=0xFFFF_FFFC, imem_ready=1 -> pc=0x0000_0000 next cycle.
REQ-040 SHALL cover resolve_valid gating: resolve_valid=0, branch_sel=11 -> no flush, pc increments by 4.
REQ-041 SHALL cover misaligned targets: branch_target=0x42 -> with PC_MISALIGN_CHECK_EN, misalign_exc pulses, pc holds and the unit stays in HALT until rst_n; without the macro, pc=0x40.
